// File: rtl/irq_gen_mc.sv
`default_nettype none
// ============================================================================
// Module   : irq_gen_mc
// Brief    : Multi-channel Rx interrupt generator. Each channel runs a small
//            FSM that watches delayed pointer-update strobes and hw/sw pointer
//            mismatch; a round-robin arbiter presents one request at a time
//            to the MSI sender on a registered irq_req/irq_vec handshake.
// Options  : IRQ_GEN_HOLDOFF_EN - builds per-channel holdoff counters loaded
//            from irq_holdoff. When undefined no counter is built,
//            irq_holdoff is ignored and HOLD always lasts one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module irq_gen_mc #(
    parameter int  NUM_CH = 4,
    parameter int  PTR_W  = 64,
    parameter int  TMR_W  = 16,
    localparam int VEC_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       hst_rdy,
    input  logic [NUM_CH-1:0]       hw_ptr_update,
    input  logic [NUM_CH*PTR_W-1:0] hw_ptr,
    input  logic [NUM_CH*PTR_W-1:0] sw_ptr,
    input  logic [TMR_W-1:0]        irq_holdoff,
    output logic                    irq_req,
    output logic [VEC_W-1:0]        irq_vec,
    input  logic                    irq_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_REQ   = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // After reset the search starts at channel 0.
    localparam logic [VEC_W-1:0] C_RR_INIT = VEC_W'(NUM_CH - 1);

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];

    logic [NUM_CH-1:0] upd_d1_q;
    logic [NUM_CH-1:0] upd_d2_q;
    logic [NUM_CH-1:0] upd_d2_d;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;

    logic              irq_req_q;
    logic [VEC_W-1:0]  irq_vec_q;
    logic [VEC_W-1:0]  rr_q;

    logic [NUM_CH-1:0] mism_w;
    logic [NUM_CH-1:0] pres_w;
    logic [NUM_CH-1:0] ack_w;
    logic [NUM_CH-1:0] want_w;
    logic [NUM_CH-1:0] idle_w;
    logic [NUM_CH-1:0] elig_w;
    logic [NUM_CH-1:0] hold_done_w;
    logic [NUM_CH-1:0] hold_load_w;
    logic [NUM_CH-1:0] hold_dec_w;

    logic              gnt_found;
    logic [VEC_W-1:0]  gnt_idx;
    logic [VEC_W-1:0]  gnt_cand;

    // Per-channel combinational status. The delayed strobe and the sticky
    // pend flag are both held at zero while the channel is IDLE so that
    // updates seen with the host not ready never turn into a stale IRQ.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign mism_w[i]   = (hw_ptr[i*PTR_W +: PTR_W] != sw_ptr[i*PTR_W +: PTR_W]);
        assign pres_w[i]   = irq_req_q && (irq_vec_q == VEC_W'(i));
        assign ack_w[i]    = pres_w[i] & irq_ack;
        assign idle_w[i]   = (state_q[i] == ST_IDLE);
        assign want_w[i]   = pend_q[i] | upd_d2_q[i] | mism_w[i];
        assign elig_w[i]   = (state_q[i] == ST_REQ) & hst_rdy[i];
        assign upd_d2_d[i] = ~idle_w[i] & upd_d1_q[i];
        // A new update wins over a simultaneous ack clear.
        assign pend_d[i]   = ~idle_w[i] & (upd_d2_q[i] | (pend_q[i] & ~ack_w[i]));
    end

`ifdef IRQ_GEN_HOLDOFF_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_hold
        logic [TMR_W-1:0] cnt_q;

        // Holdoff countdown: loaded on ack, decremented while held off
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (hold_load_w[i]) begin
                cnt_q <= irq_holdoff;
            end else if (hold_dec_w[i]) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end

        assign hold_done_w[i] = (cnt_q == '0);
    end
`else
    // Without counters HOLD always lasts exactly one cycle.
    assign hold_done_w = '1;

    logic unused_hold;
    assign unused_hold = ^{irq_holdoff, hold_load_w, hold_dec_w};
`endif

    // Per-channel next state plus holdoff load/decrement strobes
    always_comb begin
        hold_load_w = '0;
        hold_dec_w  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (hst_rdy[i]) state_d[i] = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!hst_rdy[i])    state_d[i] = ST_IDLE;
                    else if (want_w[i]) state_d[i] = ST_REQ;
                end
                ST_REQ: begin
                    // A presented request always completes its handshake,
                    // even if the host drops ready meanwhile.
                    if (pres_w[i]) begin
                        if (irq_ack) begin
                            hold_load_w[i] = 1'b1;
                            state_d[i]     = hst_rdy[i] ? ST_HOLD : ST_IDLE;
                        end
                    end else if (!hst_rdy[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!hst_rdy[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (hold_done_w[i]) begin
                        state_d[i] = want_w[i] ? ST_REQ : ST_ARMED;
                    end else begin
                        hold_dec_w[i] = 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Channel delay line, sticky pend flags and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_d1_q <= '0;
            upd_d2_q <= '0;
            pend_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
        end else begin
            upd_d1_q <= hw_ptr_update;
            upd_d2_q <= upd_d2_d;
            pend_q   <= pend_d;
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
        end
    end

    // Round-robin search starting one past the last granted channel. Only
    // channels that will still be in REQ next cycle are eligible.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        gnt_cand  = rr_q;
        for (int k = 1; k <= NUM_CH; k++) begin
            gnt_cand = VEC_W'((int'(rr_q) + k) % NUM_CH);
            if (!gnt_found && elig_w[gnt_cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = gnt_cand;
            end
        end
    end

    // Registered request/vector; one outstanding request, dropped after ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_req_q <= 1'b0;
            irq_vec_q <= '0;
            rr_q      <= C_RR_INIT;
        end else if (irq_req_q) begin
            if (irq_ack) irq_req_q <= 1'b0;
        end else if (gnt_found) begin
            irq_req_q <= 1'b1;
            irq_vec_q <= gnt_idx;
            rr_q      <= gnt_idx;
        end
    end

    assign irq_req = irq_req_q;
    assign irq_vec = irq_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_gen_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_gen_mc
// Brief    : Self-checking bench for irq_gen_mc: directed scenarios plus a
//            randomized phase compared cycle by cycle against a behavioural
//            model of the channel rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_gen_mc;

    localparam int NCH = 4;
    localparam int PW  = 64;
    localparam int TW  = 16;
    localparam int VW  = 2;

    // Model channel modes
    localparam int M_OFF  = 0;
    localparam int M_ARM  = 1;
    localparam int M_ASK  = 2;
    localparam int M_COOL = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    hst_rdy;
    logic [NCH-1:0]    hw_ptr_update;
    logic [NCH*PW-1:0] hw_ptr;
    logic [NCH*PW-1:0] sw_ptr;
    logic [TW-1:0]     irq_holdoff;
    logic              irq_req;
    logic [VW-1:0]     irq_vec;
    logic              irq_ack;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int     st       [NCH];
    longint hold_end [NCH];
    bit     d1       [NCH];
    bit     d2       [NCH];
    bit     pend     [NCH];
    bit     m_req;
    int     m_vec;
    int     m_rr;
    longint cyc = 0;

    always #5 clk = ~clk;

    irq_gen_mc #(.NUM_CH(NCH), .PTR_W(PW), .TMR_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hst_rdy      (hst_rdy),
        .hw_ptr_update(hw_ptr_update),
        .hw_ptr       (hw_ptr),
        .sw_ptr       (sw_ptr),
        .irq_holdoff  (irq_holdoff),
        .irq_req      (irq_req),
        .irq_vec      (irq_vec),
        .irq_ack      (irq_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            st[c] = M_OFF; hold_end[c] = 0; d1[c] = 0; d2[c] = 0; pend[c] = 0;
        end
        m_req = 0; m_vec = 0; m_rr = NCH - 1;
    endfunction

    // One clock of the channel rules, evaluated on the inputs seen at the edge
    function automatic void model_step();
        int  nst [NCH];
        bit  npend [NCH];
        bit  nd2 [NCH];
        int  gnt;
        int  hl;
        bit  want;
        bit  hit;
        gnt = -1;
`ifdef IRQ_GEN_HOLDOFF_EN
        hl = int'(irq_holdoff);
`else
        hl = 0;
`endif
        if (!m_req) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (gnt < 0 && st[c] == M_ASK && hst_rdy[c]) gnt = c;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            hit  = m_req && (m_vec == c) && irq_ack;
            want = pend[c] || d2[c] || (hw_ptr[c*PW +: PW] != sw_ptr[c*PW +: PW]);
            nst[c] = st[c];
            case (st[c])
                M_OFF: if (hst_rdy[c]) nst[c] = M_ARM;
                M_ARM: begin
                    if (!hst_rdy[c]) nst[c] = M_OFF;
                    else if (want)   nst[c] = M_ASK;
                end
                M_ASK: begin
                    if (m_req && m_vec == c) begin
                        if (irq_ack) begin
                            nst[c]      = hst_rdy[c] ? M_COOL : M_OFF;
                            hold_end[c] = cyc + 1 + hl;
                        end
                    end else if (!hst_rdy[c]) begin
                        nst[c] = M_OFF;
                    end
                end
                default: begin
                    if (!hst_rdy[c])            nst[c] = M_OFF;
                    else if (cyc >= hold_end[c]) nst[c] = want ? M_ASK : M_ARM;
                end
            endcase
            npend[c] = (st[c] == M_OFF) ? 1'b0 : (d2[c] ? 1'b1 : (hit ? 1'b0 : pend[c]));
            nd2[c]   = (st[c] == M_OFF) ? 1'b0 : d1[c];
        end
        for (int c = 0; c < NCH; c++) begin
            st[c] = nst[c]; pend[c] = npend[c]; d2[c] = nd2[c]; d1[c] = hw_ptr_update[c];
        end
        if (m_req) begin
            if (irq_ack) m_req = 0;
        end else if (gnt >= 0) begin
            m_req = 1; m_vec = gnt; m_rr = gnt;
        end
        cyc++;
    endfunction

    // Advance one clock and compare DUT outputs with the model
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        chk("irq_req", irq_req, m_req);
        if (m_req) chk("irq_vec", irq_vec, m_vec);
    endtask

    task automatic pulse_upd(input logic [NCH-1:0] m);
        hw_ptr_update = m;
        tick();
        hw_ptr_update = '0;
    endtask

    task automatic wait_req(input string tag, input int exp_vec);
        int n = 0;
        while (!irq_req && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, irq_req, 1);
        chk({tag, "_vec"}, irq_vec, exp_vec);
    endtask

    task automatic do_ack(input string tag);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk({tag, "_drop"}, irq_req, 0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        bit seen = 0;
        repeat (n) begin
            tick();
            seen |= irq_req;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int     idx;
        int     rises;
        longint last_rise;
        longint min_gap;
        bit     prev_req;

        rst_n = 1'b0; hst_rdy = '0; hw_ptr_update = '0;
        hw_ptr = '0; sw_ptr = '0; irq_holdoff = TW'(3); irq_ack = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_req", irq_req, 0);
        chk("rst_vec", irq_vec, 0);
        #1 rst_n = 1'b1;

        // Single channel latency: strobe in cycle t, request visible at t+4
        hst_rdy = 4'b0001;
        repeat (2) tick();
        pulse_upd(4'b0001);
        tick(); tick();
        chk("lat_t3", irq_req, 0);
        tick();
        chk("lat_t4_req", irq_req, 1);
        chk("lat_t4_vec", irq_vec, 0);
        do_ack("lat");

        // Pointer mismatch alone re-requests; catching up returns to ARMED
        repeat (6) tick();
        pulse_upd(4'b0001);
        wait_req("mis_a", 0);
        hw_ptr[0 +: PW] = 64'h10;
        sw_ptr[0 +: PW] = 64'h08;
        do_ack("mis_a");
        wait_req("mis_b", 0);
        sw_ptr[0 +: PW] = 64'h10;
        do_ack("mis_b");
        expect_quiet("mis_caught_up", 20);

        // Round-robin order 1,2,3 then wrap back to 1
        hst_rdy = 4'b1110;
        repeat (2) tick();
        pulse_upd(4'b1110);
        wait_req("rr1", 1); do_ack("rr1");
        wait_req("rr2", 2); do_ack("rr2");
        wait_req("rr3", 3); do_ack("rr3");
        repeat (6) tick();
        pulse_upd(4'b0010);
        wait_req("rr_wrap", 1); do_ack("rr_wrap");
        repeat (6) tick();

        // Host not ready on ch2: updates dropped, nothing stale on re-arm
        hst_rdy = 4'b1011;
        repeat (2) tick();
        repeat (3) begin
            pulse_upd(4'b0100);
            repeat (3) tick();
        end
        expect_quiet("nrdy_quiet", 10);
        hst_rdy = 4'b1111;
        expect_quiet("nrdy_rearm_quiet", 12);

`ifdef IRQ_GEN_HOLDOFF_EN
        // Holdoff spacing with ch0 updating every 10 cycles
        irq_holdoff = TW'(100);
        hst_rdy     = 4'b0001;
        rises = 0; last_rise = -1000; min_gap = 1000000; prev_req = 0;
        for (int cy = 0; cy < 450; cy++) begin
            hw_ptr_update = (cy % 10 == 0) ? 4'b0001 : 4'b0000;
            irq_ack       = irq_req;
            tick();
            if (irq_req && !prev_req) begin
                if (rises > 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
                last_rise = cyc;
                rises++;
            end
            prev_req = irq_req;
        end
        hw_ptr_update = '0; irq_ack = irq_req;
        tick();
        irq_ack = 1'b0;
        chk("holdoff_gap_ok", (min_gap >= 101), 1);
        chk("holdoff_count_ok", (rises >= 4), 1);
        irq_holdoff = TW'(3);
        repeat (120) tick();
        hst_rdy = 4'b1111;
        repeat (2) tick();
`endif

        // Asynchronous reset with a request outstanding
        pulse_upd(4'b0001);
        wait_req("pre_rst", 0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_req", irq_req, 0);
        model_reset();
        tick();
        #1 rst_n = 1'b1;
        expect_quiet("post_rst_quiet", 10);
        pulse_upd(4'b1000);
        wait_req("post_rst", 3);
        do_ack("post_rst");

        // Randomized traffic against the model
        for (int cy = 0; cy < 1500; cy++) begin
            if ($urandom % 40 == 0) begin
                idx = int'($urandom % NCH);
                hst_rdy[idx] = ~hst_rdy[idx];
            end
            for (int c = 0; c < NCH; c++) begin
                hw_ptr_update[c] = ($urandom % 8 == 0);
                if ($urandom % 60 == 0) hw_ptr[c*PW +: PW] = {$urandom(), $urandom()};
                if ($urandom % 12 == 0) sw_ptr[c*PW +: PW] = hw_ptr[c*PW +: PW];
            end
            if ($urandom % 200 == 0) irq_holdoff = TW'($urandom % 6);
            irq_ack = ($urandom % 3 == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_gen_mc.md
IRQ_GEN_MC -- requirements
Module: irq_gen_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of Rx channels (1..8).
REQ-002 SHALL have parameter PTR_W, default 64, hw/sw pointer width in bits.
REQ-003 SHALL have parameter TMR_W, default 16, holdoff counter width in bits.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port hst_rdy  input  NUM_CH  per-channel host-ready level.
REQ-007 SHALL have port hw_ptr_update  input  NUM_CH  per-channel one-cycle hw pointer advance strobe.
REQ-008 SHALL have port hw_ptr  input  NUM_CH*PTR_W  flattened hw pointers; channel i at bits [i*PTR_W +: PTR_W].
REQ-009 SHALL have port sw_ptr  input  NUM_CH*PTR_W  flattened sw pointers; same packing.
REQ-010 SHALL have port irq_holdoff  input  TMR_W  minimum clk cycles between IRQs on one channel.
REQ-011 SHALL have port irq_req  output  1  interrupt request to MSI sender.
REQ-012 SHALL have port irq_vec  output  max(1,clog2(NUM_CH))  channel index of current request.
REQ-013 SHALL have port irq_ack  input  1  one-cycle acceptance of current request.

Function
REQ-014 SHALL delay each hw_ptr_update bit by two registers (upd_d2) before use.
REQ-015 SHALL keep a per-channel sticky pend flag set by upd_d2, cleared when that channel's request is acked; set has priority if both occur in the same cycle.
REQ-016 SHALL run a per-channel FSM: IDLE, ARMED, REQ, HOLD.
REQ-017 IDLE -> ARMED when hst_rdy[i]=1; pend flag and upd_d2 of channel i forced to 0 while IDLE.
REQ-018 ARMED -> REQ when pend=1 or hw_ptr[i]!=sw_ptr[i].
REQ-019 REQ -> HOLD on irq_ack with irq_vec=i; holdoff counter loaded with irq_holdoff.
REQ-020 HOLD: counter decrements each cycle; at 0, -> REQ if pend=1 or hw_ptr[i]!=sw_ptr[i], else -> ARMED; irq_holdoff=0 gives 1-cycle HOLD.
REQ-021 Any state -> IDLE when hst_rdy[i] falls, except a REQ channel currently presented on irq_req, which completes the handshake first.
REQ-022 SHALL arbitrate REQ channels round-robin, search starting at last granted index +1 (mod NUM_CH); one outstanding request at a time.
REQ-023 irq_req and irq_vec SHALL be registered; both held stable from assertion until the cycle after irq_ack.
REQ-024 irq_req SHALL drop for at least one cycle after each ack; next grant earliest 2 cycles after ack.
REQ-025 irq_ack while irq_req=0 SHALL be ignored.
REQ-026 Pointer comparison SHALL be full PTR_W equality; wrap-around needs no special handling.

Reset
REQ-027 On rst_n=0: irq_req=0, irq_vec=0, all FSMs IDLE, pend flags, delay registers and counters 0, RR pointer = NUM_CH-1.
REQ-028 Reset mid-handshake SHALL abandon the request; no pending state survives.

Configuration
REQ-029 Macro IRQ_GEN_HOLDOFF_EN defined: HOLD timing per REQ-019/020.
REQ-030 Macro IRQ_GEN_HOLDOFF_EN undefined: counter not built, irq_holdoff ignored, HOLD always 1 cycle.

Verification
REQ-031 NUM_CH=4, hst_rdy=4'b0001, update ch0 at t -> irq_req=1, irq_vec=0 at t+4; ack -> irq_req=0 next cycle.
REQ-032 ch1,ch2,ch3 all pending together, ack at once -> grants in order 1,2,3; after ack of 3, new ch1 pend -> grant 1.
REQ-033 IRQ_GEN_HOLDOFF_EN, irq_holdoff=100, ch0 updates every 10 cycles -> ch0 IRQs spaced >=101 cycles apart, none lost.
REQ-034 After ack, hw_ptr[0]=0x10, sw_ptr[0]=0x08, no update -> re-request after holdoff; sw_ptr=0x10 -> return to ARMED, no IRQ.
REQ-035 hst_rdy[2] low -> ch2 updates produce no IRQ; raise hst_rdy[2] -> no stale IRQ.
REQ-036 rst_n low with irq_req=1 -> irq_req=0 asynchronously; after release no IRQ until hst_rdy and new update.
